// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: ALU select codes and FSM states.
package alu_op_sequencer_pkg;

    // ALU select codes; the slot index in res_data equals the select code
    localparam logic [1:0] OP_PRIME = 2'd0;
    localparam logic [1:0] OP_NAND  = 2'd1;
    localparam logic [1:0] OP_SUM   = 2'd2;
    localparam logic [1:0] OP_MULT  = 2'd3;

    localparam int unsigned NUM_OPS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : alu_op_sequencer_pkg

// File: rtl/alu_op_sequencer_op_mask_scan.sv
// op_mask_scan: combinational search of a 4-bit op mask.
//   mask_i  [3:0] ops still wanted
//   cur_i   [1:0] op currently running (ignored when first_i=1)
//   first_i       1 => return lowest set bit, 0 => next set bit strictly above cur_i
//   next_o  [1:0] index of the bit found (0 when none)
//   found_o       a qualifying bit exists
module op_mask_scan
    import alu_op_sequencer_pkg::*;
(
    input  logic [3:0] mask_i,
    input  logic [1:0] cur_i,
    input  logic       first_i,
    output logic [1:0] next_o,
    output logic       found_o
);

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (!found_o && mask_i[i] && (first_i || (i[1:0] > cur_i))) begin
                next_o  = i[1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule : op_mask_scan

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts {A, B, op mask} over req_valid/req_ready, steps the ALU
// select through every requested op (one per cycle, ascending), captures each ALU
// result into its slot and returns the packed word over res_valid/res_ready.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        command handshake; req_a, req_b, req_mask command fields
//   alu_a, alu_b, alu_s        drive the ALU mux; alu_o is its combinational result
//   res_valid/res_ready        result handshake; res_data (slot i = op i), res_mask
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int OPW = 2,
    parameter int RW  = 2 * OPW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPW-1:0]    req_a,
    input  logic [OPW-1:0]    req_b,
    input  logic [3:0]        req_mask,
    output logic [OPW-1:0]    alu_a,
    output logic [OPW-1:0]    alu_b,
    output logic [1:0]        alu_s,
    input  logic [RW-1:0]     alu_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*RW-1:0]   res_data,
    output logic [3:0]        res_mask
);

    state_e            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic [3:0]        mask_q, mask_d;
    logic [1:0]        cur_q, cur_d;
    logic [4*RW-1:0]   res_q, res_d;

    logic [3:0]        scan_mask;
    logic              scan_first;
    logic [1:0]        scan_next;
    logic              scan_found;

    // One scanner serves both cases: in IDLE it looks at the incoming mask for the
    // first op, in RUN it looks at the latched mask for the op after cur.
    op_mask_scan u_scan (
        .mask_i  (scan_mask),
        .cur_i   (cur_q),
        .first_i (scan_first),
        .next_o  (scan_next),
        .found_o (scan_found)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mask_d     = mask_q;
        cur_d      = cur_q;
        res_d      = res_q;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        alu_s      = OP_PRIME;
        scan_mask  = mask_q;
        scan_first = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready  = 1'b1;
                scan_mask  = req_mask;
                scan_first = 1'b1;
                if (req_valid) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    mask_d = req_mask;
                    res_d  = '0;
                    if (scan_found) begin
                        state_d = ST_RUN;
                        cur_d   = scan_next;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                alu_s = cur_q;
                for (int unsigned i = 0; i < NUM_OPS; i++) begin
                    if (cur_q == i[1:0]) begin
                        res_d[i*RW +: RW] = alu_o;
                    end
                end
                if (scan_found) begin
                    cur_d = scan_next;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            cur_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            res_q   <= res_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign res_data = res_q;
    assign res_mask = mask_q;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int OPW = 2;
    localparam int RW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_a, req_b;
    logic [3:0]     req_mask;
    logic [OPW-1:0] alu_a, alu_b;
    logic [1:0]     alu_s;
    logic [RW-1:0]  alu_o;
    logic           res_valid;
    logic           res_ready;
    logic [4*RW-1:0] res_data;
    logic [3:0]     res_mask;

    logic           use_real;
    logic [RW-1:0]  real_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.OPW(OPW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mask  (req_mask),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_o     (alu_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_mask  (res_mask)
    );

    // Real ALU mux model: prime flag, nand, sum, mult
    always_comb begin
        case (alu_s)
            2'd0:    real_o = {3'b000, (alu_a == 2'd2 || alu_a == 2'd3)};
            2'd1:    real_o = {2'b00, ~(alu_a & alu_b)};
            2'd2:    real_o = {2'b00, alu_a} + {2'b00, alu_b};
            default: real_o = {2'b00, alu_a} * {2'b00, alu_b};
        endcase
    end
    assign alu_o = use_real ? real_o : {alu_s, alu_a ^ alu_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to DONE; optionally complete the result handshake.
    task automatic do_cmd(input logic [1:0] a, input logic [1:0] b, input logic [3:0] m,
                          input logic [15:0] exp_data, input int exp_n, input bit release_res);
        int q[$];
        int cycles;
        for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_mask = m;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cycles = 0;
        while (!res_valid && cycles < 8) begin
            if (cycles < q.size()) check("alu_s_seq", {30'd0, alu_s}, q[cycles]);
            check("alu_a_run", {30'd0, alu_a}, {30'd0, a});
            check("alu_b_run", {30'd0, alu_b}, {30'd0, b});
            check("req_ready_run", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            cycles++;
        end
        check("latency", cycles, exp_n);
        check("res_valid_done", {31'd0, res_valid}, 32'd1);
        check("res_data", {16'd0, res_data}, {16'd0, exp_data});
        check("res_mask", {28'd0, res_mask}, {28'd0, m});
        check("req_ready_done", {31'd0, req_ready}, 32'd0);
        check("alu_s_done", {30'd0, alu_s}, 32'd0);
        if (release_res) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_after_hs", {31'd0, res_valid}, 32'd0);
            check("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [3:0]  mask;
        logic [15:0] exp_data;
        int          exp_n;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [15:0] held;

        vecs[0] = '{a: 2'b10, b: 2'b01, mask: 4'b1111, exp_data: 16'hFB73, exp_n: 4};
        vecs[1] = '{a: 2'b01, b: 2'b01, mask: 4'b1010, exp_data: 16'hC040, exp_n: 2};
        vecs[2] = '{a: 2'b00, b: 2'b00, mask: 4'b0000, exp_data: 16'h0000, exp_n: 0};
        vecs[3] = '{a: 2'b11, b: 2'b00, mask: 4'b0001, exp_data: 16'h0003, exp_n: 1};
        vecs[4] = '{a: 2'b01, b: 2'b11, mask: 4'b0110, exp_data: 16'h0A60, exp_n: 2};
        vecs[5] = '{a: 2'b10, b: 2'b10, mask: 4'b1000, exp_data: 16'hC000, exp_n: 1};

        use_real  = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_mask  = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        check("rst_res_mask", {28'd0, res_mask}, 32'd0);
        check("rst_alu_s", {30'd0, alu_s}, 32'd0);
        check("rst_alu_a", {30'd0, alu_a}, 32'd0);
        rst_n = 1'b1;

        // Table-driven commands with the stub ALU
        for (int i = 0; i < 6; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].mask, vecs[i].exp_data, vecs[i].exp_n, 1'b1);
        end

        // Async reset while in RUN
        @(negedge clk);
        req_valid = 1'b1; req_a = 2'b11; req_b = 2'b01; req_mask = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrun_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrun_alu_s", {30'd0, alu_s}, 32'd0);
        check("midrun_alu_a", {30'd0, alu_a}, 32'd0);
        check("midrun_alu_b", {30'd0, alu_b}, 32'd0);
        check("midrun_res_data", {16'd0, res_data}, 32'd0);
        check("midrun_res_mask", {28'd0, res_mask}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_valid", {31'd0, res_valid}, 32'd0);
            check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        end

        // Backpressure in DONE, then next command waits one cycle after the handshake
        do_cmd(2'b01, 2'b10, 4'b0011, 16'h0073, 2, 1'b0);
        held = res_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_res_data", {16'd0, res_data}, {16'd0, held});
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        req_valid = 1'b1; req_a = 2'b10; req_b = 2'b10; req_mask = 4'b0100;
        check("bp_no_bypass", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_hs_valid", {31'd0, res_valid}, 32'd0);
        check("bp_hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accepted", {31'd0, req_ready}, 32'd0);
        check("bp_new_alu_s", {30'd0, alu_s}, 32'd2);
        @(negedge clk);
        check("bp_new_valid", {31'd0, res_valid}, 32'd1);
        check("bp_new_data", {16'd0, res_data}, 32'h0000_0800);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Real ALU mux: sum and mult
        use_real = 1'b1;
        do_cmd(2'd2, 2'd3, 4'b1100, 16'h6500, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule : tb_alu_op_sequencer
